// File: rtl/exception_ctrl.sv
// Resolves MEM-stage exceptions and interrupts into one CP0 exception code (combinational, same cycle),
// then issues a one-cycle flush/redirect and masks detection for DRAIN_CYCLES while the pipeline drains.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_target_pc;
    logic        r_flush;

    logic [31:0] w_status_f;
    logic [31:0] w_cause_f;
    logic [31:0] w_epc_f;
    logic        w_int_pending;
    logic        w_detect_en;
    logic [31:0] w_code;
    logic        w_unused_ok;

    // CP0 values as they will be once the WB-stage mtc0 retires.
    always_comb begin
        w_status_f = cp0_status_i;
        w_cause_f  = cp0_cause_i;
        w_epc_f    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                5'd12: w_status_f = wb_cp0_data_i;
                5'd13: begin
                    w_cause_f[9:8] = wb_cp0_data_i[9:8];
                    w_cause_f[23]  = wb_cp0_data_i[23];
                    w_cause_f[22]  = wb_cp0_data_i[22];
                end
                5'd14: w_epc_f = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    assign w_int_pending = w_status_f[0] && !w_status_f[1] &&
                           ((w_cause_f[15:8] & w_status_f[15:8]) != 8'h00);

    // Qualifying with rst keeps every output at 0 while reset is asserted.
    assign w_detect_en = rst && (r_state == IDLE) && mem_valid_i;

    always_comb begin
        w_code = 32'h0;
        if (w_detect_en) begin
            if (w_int_pending)            w_code = 32'h1;
            else if (mem_excepttype_i[8])  w_code = 32'h8;
            else if (mem_excepttype_i[9])  w_code = 32'ha;
            else if (mem_excepttype_i[10]) w_code = 32'hd;
            else if (mem_excepttype_i[11]) w_code = 32'hc;
            else if (mem_excepttype_i[12]) w_code = 32'he;
        end
    end

    assign excepttype_o      = w_code;
    assign cur_inst_addr_o   = w_detect_en ? mem_inst_addr_i : 32'h0;
    assign is_in_delayslot_o = w_detect_en && mem_is_in_delayslot_i;
    assign flush_o           = r_flush;
    assign new_pc_o          = r_flush ? r_target_pc : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_target_pc <= 32'h0;
            r_flush     <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_code != 32'h0) begin
                        r_state     <= FLUSH;
                        r_flush     <= 1'b1;
                        r_target_pc <= (w_code == 32'he) ? w_epc_f : EXC_VECTOR;
                    end
                end
                FLUSH: begin
                    r_state <= DRAIN;
                    r_cnt   <= DRAIN_LOAD;
                end
                DRAIN: begin
                    if (r_cnt == 4'd0) r_state <= IDLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_unused_ok = ^{w_status_f[31:16], w_status_f[7:2], w_cause_f[31:16], w_cause_f[7:0],
                           mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed, table-driven bench for exception_ctrl plus hand sequences for masking and async reset.
module tb_exception_ctrl;

    localparam int unsigned DC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_excepttype_i;
    logic [31:0] mem_inst_addr_i;
    logic        mem_is_in_delayslot_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o, cur_inst_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o;

    int checks = 0;
    int errors = 0;

    exception_ctrl #(.EXC_VECTOR(32'h20), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_excepttype_i(mem_excepttype_i),
        .mem_inst_addr_i(mem_inst_addr_i), .mem_is_in_delayslot_i(mem_is_in_delayslot_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(excepttype_o), .cur_inst_addr_o(cur_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] bm;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] epc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_code;
        logic [31:0] e_pc;
        logic        e_ds;
        logic [31:0] e_npc;
    } vec_t;

    localparam int NV = 16;
    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_valid_i = 1'b0; mem_excepttype_i = 32'h0; mem_inst_addr_i = 32'h0;
        mem_is_in_delayslot_i = 1'b0; cp0_status_i = 32'h0; cp0_cause_i = 32'h0;
        cp0_epc_i = 32'h0; wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    task automatic drive_mem(input logic [31:0] bm, input logic [31:0] pc);
        drive_idle();
        mem_valid_i = 1'b1; mem_excepttype_i = bm; mem_inst_addr_i = pc;
    endtask

    task automatic apply(input vec_t t);
        mem_valid_i = t.vld; mem_excepttype_i = t.bm; mem_inst_addr_i = t.pc;
        mem_is_in_delayslot_i = t.ds; cp0_status_i = t.st; cp0_cause_i = t.ca;
        cp0_epc_i = t.epc; wb_cp0_we_i = t.we; wb_cp0_waddr_i = t.wa; wb_cp0_data_i = t.wd;
    endtask

    initial begin
        //          vld   bitmap        pc            ds    status        cause         epc           we    wa     wdata         code   cur_pc        ds    new_pc
        v[0]  = '{1'b1, 32'h0000_0100, 32'h8000_0010, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h8, 32'h8000_0010, 1'b0, 32'h20};
        v[1]  = '{1'b1, 32'h0000_0A00, 32'h0000_1000, 1'b0, 32'h0000_FF01, 32'h0000_0400, 32'h0,       1'b0, 5'd0,  32'h0,        32'h1, 32'h0000_1000, 1'b0, 32'h20};
        v[2]  = '{1'b1, 32'h0,        32'h0000_2000, 1'b0, 32'h0000_FF03, 32'h0000_0400, 32'h0,       1'b1, 5'd12, 32'h0000_FF01, 32'h1, 32'h0000_2000, 1'b0, 32'h20};
        v[3]  = '{1'b1, 32'h0,        32'h0000_2004, 1'b0, 32'h0000_FF03, 32'h0000_0400, 32'h0,       1'b0, 5'd12, 32'h0000_FF01, 32'h0, 32'h0000_2004, 1'b0, 32'h0};
        v[4]  = '{1'b1, 32'h0000_1000, 32'h0000_3000, 1'b0, 32'h0,        32'h0,        32'h0000_0100, 1'b1, 5'd14, 32'h0000_0200, 32'he, 32'h0000_3000, 1'b0, 32'h200};
        v[5]  = '{1'b1, 32'h0000_1000, 32'h0000_3004, 1'b0, 32'h0,        32'h0,        32'h0000_0300, 1'b0, 5'd14, 32'h0000_0200, 32'he, 32'h0000_3004, 1'b0, 32'h300};
        v[6]  = '{1'b0, 32'h0000_0100, 32'h0000_4000, 1'b1, 32'h0000_FF01, 32'h0000_0400, 32'h0,       1'b0, 5'd0,  32'h0,        32'h0, 32'h0,         1'b0, 32'h0};
        v[7]  = '{1'b1, 32'h0000_0200, 32'h0000_5000, 1'b1, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'ha, 32'h0000_5000, 1'b1, 32'h20};
        v[8]  = '{1'b1, 32'h0000_0400, 32'h0000_5004, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'hd, 32'h0000_5004, 1'b0, 32'h20};
        v[9]  = '{1'b1, 32'h0000_0800, 32'h0000_5008, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'hc, 32'h0000_5008, 1'b0, 32'h20};
        v[10] = '{1'b1, 32'hFFFF_E0FF, 32'h0000_500C, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0, 32'h0000_500C, 1'b0, 32'h0};
        v[11] = '{1'b1, 32'h0000_0900, 32'h0000_6000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h8, 32'h0000_6000, 1'b0, 32'h20};
        v[12] = '{1'b1, 32'h0,        32'h0000_7000, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 5'd13, 32'h0000_0100, 32'h1, 32'h0000_7000, 1'b0, 32'h20};
        v[13] = '{1'b1, 32'h0,        32'h0000_7004, 1'b0, 32'h0000_0401, 32'h0,        32'h0,        1'b1, 5'd13, 32'h0000_0400, 32'h0, 32'h0000_7004, 1'b0, 32'h0};
        v[14] = '{1'b1, 32'h0,        32'h0000_7008, 1'b0, 32'h0000_0400, 32'h0000_0400, 32'h0,       1'b0, 5'd0,  32'h0,        32'h0, 32'h0000_7008, 1'b0, 32'h0};
        v[15] = '{1'b1, 32'h0,        32'h0000_700C, 1'b0, 32'h0,        32'h0000_0400, 32'h0,        1'b0, 5'd12, 32'h0000_FF01, 32'h0, 32'h0000_700C, 1'b0, 32'h0};

        // Reset: outputs stay 0 even with a syscall presented.
        rst = 1'b0;
        drive_mem(32'h100, 32'h8000_0010);
        #12;
        chk("rst_code", excepttype_o, 32'h0);
        chk("rst_pc", cur_inst_addr_o, 32'h0);
        chk("rst_flush", flush_o, 1'b0);
        chk("rst_npc", new_pc_o, 32'h0);
        drive_idle();
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(v[i]);
            #1;
            chk($sformatf("v%0d_code", i), excepttype_o, v[i].e_code);
            chk($sformatf("v%0d_pc", i), cur_inst_addr_o, v[i].e_pc);
            chk($sformatf("v%0d_ds", i), is_in_delayslot_o, v[i].e_ds);
            @(posedge clk); #1;
            drive_idle();
            chk($sformatf("v%0d_flush", i), flush_o, v[i].e_code != 32'h0);
            chk($sformatf("v%0d_npc", i), new_pc_o, (v[i].e_code != 32'h0) ? v[i].e_npc : 32'h0);
            for (int k = 0; k < DC; k++) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d_drain_flush%0d", i, k), flush_o, 1'b0);
                chk($sformatf("v%0d_drain_npc%0d", i, k), new_pc_o, 32'h0);
            end
            @(posedge clk);
        end

        // Masking: overflow in N, trap in N+1 is hidden until IDLE returns at N+2+DC.
        @(negedge clk);
        drive_mem(32'h800, 32'h0000_8000);
        #1 chk("mask_ovf", excepttype_o, 32'hc);
        @(posedge clk); #1;
        drive_mem(32'h400, 32'h0000_8004);
        #1;
        chk("mask_flush", flush_o, 1'b1);
        chk("mask_flush_code", excepttype_o, 32'h0);
        chk("mask_flush_pc", cur_inst_addr_o, 32'h0);
        for (int k = 0; k < DC; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mask_drain_code%0d", k), excepttype_o, 32'h0);
            chk($sformatf("mask_drain_flush%0d", k), flush_o, 1'b0);
        end
        @(posedge clk); #1;
        chk("mask_retry_code", excepttype_o, 32'hd);
        chk("mask_retry_pc", cur_inst_addr_o, 32'h0000_8004);
        @(posedge clk); #1;
        drive_idle();
        chk("mask_retry_flush", flush_o, 1'b1);
        repeat (DC + 1) @(posedge clk);

        // Async reset during the flush pulse.
        @(negedge clk);
        drive_mem(32'h100, 32'h0000_9000);
        @(posedge clk); #1;
        chk("arst1_flush_pre", flush_o, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst1_flush", flush_o, 1'b0);
        chk("arst1_npc", new_pc_o, 32'h0);
        chk("arst1_code", excepttype_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        #1 chk("arst1_redetect", excepttype_o, 32'h8);
        @(posedge clk); #1;
        drive_idle();
        chk("arst1_reflush", flush_o, 1'b1);

        // Async reset during DRAIN, then a fresh syscall.
        @(posedge clk); #1;
        drive_mem(32'h100, 32'h0000_A000);
        #1 chk("arst2_masked", excepttype_o, 32'h0);
        rst = 1'b0;
        #1;
        chk("arst2_code", excepttype_o, 32'h0);
        chk("arst2_flush", flush_o, 1'b0);
        chk("arst2_npc", new_pc_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("arst2_new_code", excepttype_o, 32'h8);
        chk("arst2_new_pc", cur_inst_addr_o, 32'h0000_A000);
        @(posedge clk); #1;
        drive_idle();
        chk("arst2_new_flush", flush_o, 1'b1);
        chk("arst2_new_npc", new_pc_o, 32'h20);
        repeat (DC + 2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
